// File: rtl/float_argmax_seq.sv
// float_argmax_seq: streams a float32 vector through one shared A>=B comparator and
// returns the maximum value and the index of its first occurrence.
// Latency: out_valid in the cycle after the last accepted beat; a zero-length vector
// gives out_valid in the cycle after start.
// Backpressure: in_ready is high only in RUN (in_valid low stalls at no cost); the
// result is held in DONE until out_ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, len        begin a vector of len elements (sampled in IDLE only)
//   abort             synchronous cancel back to IDLE; result registers hold
//   in_valid/in_ready/in_data   element stream, one element per handshake
//   out_valid/out_ready         result handshake
//   max_val, max_idx  maximum element bit pattern and its first index
//   busy              high in any state other than IDLE

// float_compare: combinational IEEE-754 single-precision A >= B.
// Latency: none (pure combinational).
// Backpressure: none.
//
// Ordering is sign, then exponent, then mantissa. +0 ranks above -0 because
// the sign is decided first, and NaNs fall into place by their bit pattern.
module float_compare (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge
);

  always_comb begin
    ge = 1'b0;
    if (a[31] != b[31]) begin
      // Different signs: the non-negative operand is the larger one.
      ge = ~a[31];
    end else if (!a[31]) begin
      // Both positive: exponent:mantissa compares as an unsigned integer.
      ge = (a[30:0] >= b[30:0]);
    end else begin
      // Both negative: larger magnitude means smaller value.
      ge = (a[30:0] <= b[30:0]);
    end
  end

endmodule

module float_argmax_seq #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      max_val,
  output logic [IDX_W-1:0] max_idx,
  output logic             busy
);

  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  // Index of the final element, captured at start so the end-of-vector test
  // is a plain equality against cnt.
  logic [IDX_W-1:0] last_idx;

  logic             cmp_ge;
  logic             beat;

  // The single shared comparator: running maximum against the incoming element.
  float_compare u_cmp (
    .a  (max_val),
    .b  (in_data),
    .ge (cmp_ge)
  );

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from any input to in_ready or out_valid.
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign beat = in_ready & in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_idx <= '0;
      max_val  <= 32'h0;
      max_idx  <= '0;
    end else if (abort) begin
      // Cancel wins over start, beats and the result handshake; the result
      // registers deliberately keep whatever they held.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              last_idx <= len - 1'b1;
              cnt      <= '0;
              state    <= RUN;
            end else begin
              // Empty vector: report -inf at index 0 without entering RUN.
              max_val <= NEG_INF;
              max_idx <= '0;
              state   <= DONE;
            end
          end
        end

        RUN: begin
          if (beat) begin
            // First element seeds the maximum; later ones replace it only
            // when strictly greater (comparator says max_val < in_data), so
            // ties keep the earlier index.
            if ((cnt == '0) || !cmp_ge) begin
              max_val <= in_data;
              max_idx <= cnt;
            end
            cnt <= cnt + 1'b1;
            if (cnt == last_idx) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
